// File: rtl/kgp_instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : kgp_instr_sequencer_if
// Description : Control/status bundle between the KGP-RISC sequencer and the
//               datapath/control unit. The sequencer owns the PC side
//               (master), and the datapath/control unit drives the decode side
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface kgp_instr_sequencer_if;
    logic        run;
    logic [31:0] nextInstrAddr;
    logic        isLoad;
    logic        isStore;
    logic        regWriteReq;
    logic        haltInstr;
    logic [31:0] instrAddr;
    logic        regWriteEn;
    logic        memWriteEn;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] retiredCount;

    modport master (
        input  run, nextInstrAddr, isLoad, isStore, regWriteReq, haltInstr,
        output instrAddr, regWriteEn, memWriteEn, state, halted, retiredCount
    );

    modport slave (
        output run, nextInstrAddr, isLoad, isStore, regWriteReq, haltInstr,
        input  instrAddr, regWriteEn, memWriteEn, state, halted, retiredCount
    );
endinterface
`default_nettype wire

// File: rtl/kgp_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kgp_instr_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Owns the PC,
//               turns level decode requests into one-cycle commit strobes and
//               counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module kgp_instr_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    // Retired-count value after reset; nonzero only for bring-up/preload use.
    parameter logic [31:0] RESET_COUNT = 32'h0000_0000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    kgp_instr_sequencer_if.master   bus_if
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        load_q;
    logic        store_q;
    logic        regwr_q;
    logic        halt_q;
    logic [31:0] count_d;

    assign count_d = count_q + 32'd1;

    // Sequencer FSM: steps one instruction at a time, latching decode flags in
    // DECODE and committing PC/count at the WB edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            count_q <= RESET_COUNT;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            regwr_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.run) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    load_q  <= bus_if.isLoad;
                    store_q <= bus_if.isStore;
                    regwr_q <= bus_if.regWriteReq;
                    // halt_q doubles as the registered halted output: it is
                    // only set on the edge that enters HALT.
                    halt_q  <= bus_if.haltInstr;
                    state_q <= bus_if.haltInstr ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    state_q <= (load_q || store_q) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    pc_q    <= bus_if.nextInstrAddr;
                    count_q <= count_d;
                    state_q <= bus_if.run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign bus_if.regWriteEn   = (state_q == ST_WB)  && regwr_q;
    assign bus_if.memWriteEn   = (state_q == ST_MEM) && store_q;
    assign bus_if.instrAddr    = pc_q;
    assign bus_if.retiredCount = count_q;
    assign bus_if.state        = state_q;
    assign bus_if.halted       = halt_q;

endmodule
`default_nettype wire
